// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB bus signals between the PPC bus master and the register-bank slave.
// Bit 0 is the MSB on every OPB vector, matching the bus documentation.
interface opb_register_bank_ppc2simulink_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing NUM_REGS software-written control words to fabric logic,
// with per-register read-only status capture and auto-clearing pulse modes.

module opb_regbank_word #(
    parameter logic [31:0] RESET_VALUE = '0,
    parameter bit          AUTOCLEAR   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] q
);
    logic [31:0] q_nxt;

    always_comb begin
        q_nxt = AUTOCLEAR ? RESET_VALUE : q;
        if (wr_en) begin
            q_nxt = q;
            for (int b = 0; b < 4; b++)
                if (be[b]) q_nxt[8*b +: 8] = wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RESET_VALUE;
        else        q <= q_nxt;
    end
endmodule

module opb_register_bank_ppc2simulink #(
    parameter logic [31:0]         C_BASEADDR     = 32'h01004000,
    parameter logic [31:0]         C_HIGHADDR     = 32'h010040FF,
    parameter int                  C_OPB_AWIDTH   = 32,
    parameter int                  C_OPB_DWIDTH   = 32,
    parameter int                  NUM_REGS       = 8,
    parameter logic [31:0]         RESET_VALUE    = 32'h00000000,
    parameter logic [NUM_REGS-1:0] RO_MASK        = '0,
    parameter logic [NUM_REGS-1:0] AUTOCLEAR_MASK = '0
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    opb_register_bank_ppc2simulink_if.slave opb,
    output logic [NUM_REGS*32-1:0]    user_data_out,
    output logic [NUM_REGS-1:0]       user_strobe,
    input  logic [NUM_REGS*32-1:0]    user_data_in
);
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
    state_t state, state_nxt;

    logic [C_OPB_AWIDTH-1:0] addr;
    logic [C_OPB_DWIDTH-1:0] wdata;
    logic [3:0]              be;
    logic [31:0]             off;
    logic [IW-1:0]           idx;
    logic                    hit, in_rng, capture, ack, commit;
    logic [31:0]             rd_nxt;

    logic                    rnw_q, in_rng_q;
    logic [IW-1:0]           idx_q;
    logic [3:0]              be_q;
    logic [31:0]             wdata_q, rd_q;

    logic [NUM_REGS-1:0][31:0] words, din;
    logic [NUM_REGS-1:0]       wr_en;
    logic                      unused_seq;

    // OPB vectors are MSB-first; plain assignment keeps the numeric value,
    // so BE[0] lands on be[3] (bits 31:24) as the bus expects.
    assign addr       = opb.OPB_ABus;
    assign wdata      = opb.OPB_DBus;
    assign be         = opb.OPB_BE;
    assign unused_seq = opb.OPB_seqAddr;
    assign din        = user_data_in;

    assign hit     = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign off     = addr - C_BASEADDR;
    assign in_rng  = off < 32'(4 * NUM_REGS);
    assign idx     = off[IW+1:2];
    assign capture = (state == IDLE) && hit;

    always_comb begin
        rd_nxt = '0;
        if (in_rng) rd_nxt = RO_MASK[idx] ? din[idx] : words[idx];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hit) state_nxt = ACK;
            ACK:     state_nxt = HOLD;
            HOLD:    if (!opb.OPB_select) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Request fields and read data are frozen on the hit cycle.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            rnw_q    <= 1'b1;
            in_rng_q <= 1'b0;
            idx_q    <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
        end else if (capture) begin
            rnw_q    <= opb.OPB_RNW;
            in_rng_q <= in_rng;
            idx_q    <= idx;
            be_q     <= be;
            wdata_q  <= 32'(wdata);
            rd_q     <= rd_nxt;
        end
    end

    // Ack is gated by live select so an abandoned transfer is never acked.
    assign ack    = (state == ACK) && opb.OPB_select;
    assign commit = ack && !rnw_q && in_rng_q && !RO_MASK[idx_q];

    genvar i;
    generate
        for (i = 0; i < NUM_REGS; i++) begin : g_word
            assign wr_en[i] = commit && (idx_q == IW'(i));
            opb_regbank_word #(
                .RESET_VALUE (RESET_VALUE),
                .AUTOCLEAR   (AUTOCLEAR_MASK[i])
            ) u_word (
                .clk   (OPB_Clk),
                .rst_n (OPB_Rst_n),
                .wr_en (wr_en[i]),
                .be    (be_q),
                .wdata (wdata_q),
                .q     (words[i])
            );
        end
    endgenerate

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) user_strobe <= '0;
        else            user_strobe <= wr_en;
    end

    assign user_data_out  = words;
    assign opb.Sl_DBus    = ack ? rd_q : 32'h0;
    assign opb.Sl_xferAck = ack;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;
endmodule
